axis_output_framer: RTL and testbench

- Output stage fed by the transmission-estimation / scene-recovery block; consumes recovered pixels {J_R, J_G, J_B} with their valid strobe.
- Buffers pixels in a small FIFO so M_AXIS_TREADY backpressure is honoured instead of ignored.
- Generates a 32-bit AXI4-Stream master with TLAST on the final pixel of each frame, plus a frame-done pulse and a sticky overflow flag.
- The producer cannot be stalled, so the FIFO absorbs short backpressure bursts only.

---
 rtl/haze_pkg.sv | 19 +
 rtl/axis_output_framer_if.sv | 17 +
 rtl/axis_output_framer_sync_fifo.sv | 83 ++++++++
 rtl/axis_output_framer.sv | 78 +++++++
 tb/tb_axis_output_framer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal output path.
//   - default image geometry and pixel width
//   - AXI4-Stream data width
//   - rgb888_t: recovered pixel {r, g, b}
package haze_pkg;

    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int PIX_W          = 24;
    localparam int FRAME_PIXELS   = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;
    localparam int AXIS_DATA_W    = 32;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/axis_output_framer_if.sv
// AXI4-Stream link carrying one packed pixel per beat.
//   tdata  : AXIS_DATA_W-bit beat
//   tvalid : beat valid (master)
//   tready : sink ready (slave)
//   tlast  : last beat of a frame (master)
interface axis_output_framer_if;
    import haze_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_output_framer_sync_fifo.sv
// Synchronous FIFO with a show-ahead output register.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : push request and data
//   rd_en             : pop the presented word (ignored while rd_valid=0)
//   rd_data, rd_valid : presented head-of-queue word
//   level             : occupancy, output register included
//   full              : level == DEPTH
// Total capacity is DEPTH: the output register holds one word and the RAM
// holds at most DEPTH-1, so a DEPTH-entry RAM with natural pointer wrap never
// overruns.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [LW-1:0]    level,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             wr_ok;
    logic             ram_empty;
    logic             load_out;
    logic             take_ram;
    logic             bypass;
    logic             ram_wr;

    always_comb begin
        full      = (level == LW'(DEPTH));
        pop       = rd_en & rd_valid;
        // a full FIFO still accepts a write when the head is leaving
        wr_ok     = wr_en & (~full | pop);
        ram_empty = (level == LW'(rd_valid));
        load_out  = ~rd_valid | pop;
        take_ram  = load_out & ~ram_empty;
        // empty RAM and a free output slot: new word goes straight to output
        bypass    = load_out & ram_empty & wr_ok;
        ram_wr    = wr_ok & ~bypass;
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            level    <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (take_ram) begin
                rd_data  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
                rd_valid <= 1'b1;
            end else if (bypass) begin
                rd_data  <= wr_data;
                rd_valid <= 1'b1;
            end else if (load_out) begin
                rd_valid <= 1'b0;
            end
            level <= level + LW'(wr_ok) - LW'(pop);
        end
    end

endmodule

// File: rtl/axis_output_framer.sv
// Output framer: buffers recovered pixels and emits them as a 32-bit
// AXI4-Stream with TLAST on the final pixel of each frame.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid, in_pixel: recovered pixel {R,G,B} from the upstream stage
//   m_axis            : AXI4-Stream master (tdata = {8'h00,R,G,B})
//   fifo_level        : buffered pixels, output register included
//   overflow          : sticky, a pixel arrived while the FIFO was full
//   frame_done        : one-cycle pulse after each TLAST handshake
module axis_output_framer #(
    parameter int IMG_WIDTH  = haze_pkg::IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = haze_pkg::IMG_HEIGHT_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_W      = haze_pkg::PIX_W,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PIX_W-1:0]     in_pixel,
    axis_output_framer_if.master m_axis,
    output logic [LW-1:0]        fifo_level,
    output logic                 overflow,
    output logic                 frame_done
);
    import haze_pkg::*;

    localparam int FRAME = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = $clog2(FRAME);

    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             handshake;
    logic [CW-1:0]    beat_cnt;
    logic             last_beat;
    rgb888_t          out_pix;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (in_valid),
        .wr_data  (in_pixel),
        .rd_en    (m_axis.tready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (fifo_level),
        .full     (full)
    );

    assign out_pix   = rd_data;
    assign last_beat = (beat_cnt == CW'(FRAME - 1));
    assign handshake = rd_valid & m_axis.tready;

    assign m_axis.tvalid = rd_valid;
    assign m_axis.tdata  = {8'h00, out_pix.r, out_pix.g, out_pix.b};
    // beat_cnt only moves on a handshake, so tlast is stable while stalled
    assign m_axis.tlast  = rd_valid & last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= handshake & last_beat;
            if (handshake) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
            end
            if (in_valid & full & ~handshake) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_output_framer.sv
module tb_axis_output_framer;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [23:0] in_pixel;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        frame_done;

    axis_output_framer_if m_axis ();

    axis_output_framer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (DEPTH),
        .PIX_W      (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .m_axis     (m_axis),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: queue of accepted, not yet delivered pixels
    logic [23:0] q [$];
    int          beats;
    bit          m_ovf;
    bit          m_fd;
    logic [31:0] last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        beats     = 0;
        m_ovf     = 1'b0;
        m_fd      = 1'b0;
        last_data = '0;
    endtask

    task automatic model_edge(input logic v, input logic [23:0] p, input logic rdy);
        bit hs;
        bit was_full;
        hs       = (q.size() > 0) && rdy;
        was_full = (q.size() == DEPTH);
        m_fd     = 1'b0;
        if (hs) begin
            void'(q.pop_front());
            m_fd  = (beats == FRAME - 1);
            beats = (beats + 1) % FRAME;
        end
        if (v) begin
            if (!was_full || hs) q.push_back(p);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        bit          ev;
        logic [31:0] ed;
        ev = (q.size() > 0);
        ed = ev ? {8'h00, q[0]} : last_data;
        check("tvalid", {31'd0, m_axis.tvalid}, {31'd0, ev});
        check("tdata", m_axis.tdata, ed);
        check("tlast", {31'd0, m_axis.tlast}, {31'd0, ev && beats == FRAME - 1});
        check("fifo_level", {27'd0, fifo_level}, q.size());
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        if (ev) last_data = ed;
    endtask

    task automatic step(input logic v, input logic [23:0] p, input logic rdy);
        in_valid      = v;
        in_pixel      = p;
        m_axis.tready = rdy;
        @(posedge clk);
        model_edge(v, p, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_pixel      = '0;
        m_axis.tready = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b1);
    endtask

    function automatic logic [23:0] rnd_pix();
        return 24'($urandom());
    endfunction

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_pixel      = '0;
        m_axis.tready = 1'b0;
        model_clear();

        // reset state
        do_reset();

        // continuous frame 0x000001..0x000010
        for (int i = 1; i <= FRAME; i++) step(1'b1, 24'(i), 1'b1);
        drain(4);

        // backpressure: 10 stalled writes, then release
        for (int i = 0; i < 10; i++) step(1'b1, rnd_pix(), 1'b0);
        check("bp_level10", {27'd0, fifo_level}, 32'd10);
        for (int i = 0; i < 6; i++) step(1'b1, rnd_pix(), 1'b1);
        drain(14);

        // overflow: 17 writes against a stalled sink
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rnd_pix(), 1'b0);
        check("ovf_level_sat", {27'd0, fifo_level}, 32'd16);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        drain(DEPTH + 2);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // full with simultaneous read and write
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_pix(), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, rnd_pix(), 1'b1);
        check("full_rw_level", {27'd0, fifo_level}, 32'd16);
        check("full_rw_no_ovf", {31'd0, overflow}, 32'd0);
        drain(DEPTH + 2);

        // two back-to-back frames
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, rnd_pix(), 1'b1);
        drain(3);

        // reset mid-frame after 7 beats, then a clean frame
        for (int i = 0; i < 7; i++) step(1'b1, rnd_pix(), 1'b1);
        do_reset();
        check("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        check("rst_level", {27'd0, fifo_level}, 32'd0);
        for (int i = 0; i < FRAME; i++) step(1'b1, rnd_pix(), 1'b1);
        drain(3);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 60, rnd_pix(), $urandom_range(0, 99) < 70);
        drain(DEPTH + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
